// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sequence detector.
package seq_det_pkg;

    localparam int          DEF_PAT_W   = 6;
    localparam logic [15:0] DEF_PATTERN = 16'b101011;
    localparam int          DEF_CNT_W   = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Longest proper border of the first k bits of pat (MSB-first, w bits wide).
    function automatic int fail_len(input logic [15:0] pat, input int w, input int k);
        int best;
        bit ok;
        best = 0;
        for (int b = 1; b < k; b++) begin
            ok = 1'b1;
            for (int i = 0; i < b; i++) begin
                if (pat[w-1-i] != pat[w-1-(k-b)-i]) ok = 1'b0;
            end
            if (ok) best = b;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Moore serial pattern detector with elaboration-time KMP transition table.
// Optional hit counter built only when SEQ_DET_CNT_EN is defined; otherwise cnt is tied to 0.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic                        ck,
    input  logic                        rs,
    input  logic                        s,
    input  logic                        s_vld,
    input  logic                        ovl,
    output logic [clog2(PAT_W+1)-1:0]   st,
    output logic                        y,
    output logic [CNT_W-1:0]            cnt
);

    localparam int SW = clog2(PAT_W + 1);
    localparam int TW = (PAT_W + 1) * SW;

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $fatal(1, "seq_det_param: PAT_W=%0d outside 2..16", PAT_W);
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $fatal(1, "seq_det_param: CNT_W=%0d outside 1..16", CNT_W);
    end

    // Follow failure links until bit b extends a prefix or we fall to state 0.
    function automatic int delta(input int k0, input logic b);
        int  k;
        int  r;
        bit  done;
        k    = k0;
        r    = 0;
        done = 1'b0;
        for (int it = 0; it <= PAT_W + 1; it++) begin
            if (!done) begin
                if (k < PAT_W && b == PATTERN[PAT_W-1-k]) begin
                    r    = k + 1;
                    done = 1'b1;
                end else if (k == 0) begin
                    r    = 0;
                    done = 1'b1;
                end else begin
                    k = fail_len(16'(PATTERN), PAT_W, k);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] build_tbl(input logic b);
        logic [TW-1:0] t;
        t = '0;
        for (int k = 0; k <= PAT_W; k++) t[k*SW +: SW] = SW'(delta(k, b));
        return t;
    endfunction

    // Entry k holds the next state from state k; entry PAT_W is the overlapping exit.
    localparam logic [TW-1:0] NXT0 = build_tbl(1'b0);
    localparam logic [TW-1:0] NXT1 = build_tbl(1'b1);
    localparam logic [SW-1:0] ST_FULL = SW'(PAT_W);

    logic [SW-1:0] st_q;
    logic [SW-1:0] st_d;

    always_comb begin
        st_d = st_q;
        if (s_vld) begin
            if (st_q == ST_FULL && !ovl) st_d = s ? NXT1[SW-1:0] : NXT0[SW-1:0];
            else                         st_d = s ? NXT1[int'(st_q)*SW +: SW]
                                                  : NXT0[int'(st_q)*SW +: SW];
        end
    end

    always_ff @(posedge ck) begin
        if (rs) st_q <= '0;
        else    st_q <= st_d;
    end

    assign st = st_q;
    assign y  = (st_q == ST_FULL);

`ifdef SEQ_DET_CNT_EN
    logic hit;
    assign hit = s_vld && (st_d == ST_FULL);

    seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk_i (ck),
        .clr_i (rs),
        .inc_i (hit),
        .cnt_o (cnt)
    );
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench: two detector configurations share one stimulus stream and are
// checked against a brute-force suffix/prefix model of the match length.
module tb_seq_det_param;

    localparam int          AW   = 6;
    localparam logic [15:0] APAT = 16'b101011;
    localparam int          ACW  = 8;
    localparam int          BW   = 3;
    localparam logic [15:0] BPAT = 16'b111;
    localparam int          BCW  = 2;

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic       s = 1'b0;
    logic       s_vld = 1'b0;
    logic       ovl = 1'b1;
    logic [2:0] st_a;
    logic       y_a;
    logic [7:0] cnt_a;
    logic [1:0] st_b;
    logic       y_b;
    logic [1:0] cnt_b;

    seq_det_param u_a (
        .ck(ck), .rs(rs), .s(s), .s_vld(s_vld), .ovl(ovl),
        .st(st_a), .y(y_a), .cnt(cnt_a)
    );

    seq_det_param #(.PAT_W(BW), .PATTERN(3'b111), .CNT_W(BCW)) u_b (
        .ck(ck), .rs(rs), .s(s), .s_vld(s_vld), .ovl(ovl),
        .st(st_b), .y(y_b), .cnt(cnt_b)
    );

    always #5 ck = ~ck;

    typedef struct {
        int st_a;
        int cnt_a;
        int st_b;
        int cnt_b;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    logic [15:0] ha_bits = '0, hb_bits = '0;
    int          ha_len = 0, hb_len = 0;
    int          sa_m = 0, sb_m = 0, ca_m = 0, cb_m = 0;

    // History since the last restart point; state is the longest suffix that is a pattern prefix.
    function automatic void mstep(input int w, input logic [15:0] pat, input int cmax,
                                  input bit b, input bit ov,
                                  inout logic [15:0] hbits, inout int hlen,
                                  inout int st, inout int cnt);
        bit ok;
        int top;
        if (st == w && !ov) hlen = 0;
        hbits = {hbits[14:0], b};
        if (hlen < w) hlen++;
        top = (hlen < w) ? hlen : w;
        st = 0;
        for (int k = top; k >= 1; k--) begin
            if (st == 0) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (hbits[k-1-i] != pat[w-1-i]) ok = 1'b0;
                if (ok) st = k;
            end
        end
        if (st == w && cnt < cmax) cnt++;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef SEQ_DET_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge ck) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("st_a",  int'(st_a),  e.st_a);
            check("y_a",   int'(y_a),   int'(e.st_a == AW));
            check("cnt_a", int'(cnt_a), exp_cnt(e.cnt_a));
            check("st_b",  int'(st_b),  e.st_b);
            check("y_b",   int'(y_b),   int'(e.st_b == BW));
            check("cnt_b", int'(cnt_b), exp_cnt(e.cnt_b));
        end
    end

    task automatic cyc(input bit b, input bit v, input bit o, input bit r);
        exp_t e;
        @(negedge ck);
        s = b; s_vld = v; ovl = o; rs = r;
        if (r) begin
            ha_len = 0; hb_len = 0;
            sa_m = 0; sb_m = 0; ca_m = 0; cb_m = 0;
        end else if (v) begin
            mstep(AW, APAT, (1 << ACW) - 1, b, o, ha_bits, ha_len, sa_m, ca_m);
            mstep(BW, BPAT, (1 << BCW) - 1, b, o, hb_bits, hb_len, sb_m, cb_m);
        end
        e.st_a = sa_m; e.cnt_a = ca_m; e.st_b = sb_m; e.cnt_b = cb_m;
        sbq.push_back(e);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit o);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, o, 1'b0);
    endtask

    initial begin
        logic [15:0] stream;
        stream = 16'b10101101011;

        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        send_bits(stream, 11, 1'b1);
        cyc(0, 0, 1, 1);
        send_bits(stream, 11, 1'b0);
        cyc(0, 0, 1, 1);
        send_bits(16'h003f, 6, 1'b1);
        cyc(0, 0, 1, 1);
        send_bits(16'h003f, 6, 1'b0);
        cyc(0, 0, 1, 1);
        for (int i = 5; i >= 0; i--) begin
            cyc(APAT[i], 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(0, 0, 1, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int h = 0; h < 5; h++) send_bits(16'b01011, 5, 1'b1);
        cyc(0, 0, 1, 1);
        send_bits(16'b10101, 5, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(APAT, 6, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_bits(APAT, 6, 1'($urandom_range(0, 1)));
            end else begin
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
            end
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge ck);
        #3;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
